// File: rtl/preproc_pkg.sv
// Shared constants, state/bank types and the zigzag scan table for the 8x8 block path.
package preproc_pkg;

    localparam int DEF_DATA_W = 12;
    localparam int BLK_N      = 8;
    localparam int BLK_SZ     = 64;

    typedef logic bank_t;

    typedef enum logic {
        S_IDLE,
        S_STREAM
    } state_t;

    // Scan index -> raster position (row*8 + col), standard JPEG order.
    localparam logic [5:0] ZIGZAG [BLK_SZ] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

endpackage

// File: rtl/block_bank.sv
// 8x8 sample store: one full row written per cycle, one element read combinationally.
module block_bank
    import preproc_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                    i_clk,
    input  logic                    wr_en,
    input  logic [2:0]              wr_row,
    input  logic [BLK_N*DATA_W-1:0] wr_data,
    input  logic [5:0]              rd_addr,
    output logic [DATA_W-1:0]       rd_data
);

    logic [DATA_W-1:0] mem [BLK_SZ];

    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            for (int c = 0; c < BLK_N; c++) begin
                mem[{wr_row, c[2:0]}] <= wr_data[c*DATA_W +: DATA_W];
            end
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/block_serializer.sv
// Reassembles 8-lane row vectors into ping-pong 8x8 banks and replays each block one sample per handshake;
// first sample one edge after the 8th vector, overflow flagged (no upstream ready). ZIGZAG_SCAN_EN selects zigzag order.
module block_serializer
    import preproc_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data0,
    input  logic [DATA_W-1:0] i_data1,
    input  logic [DATA_W-1:0] i_data2,
    input  logic [DATA_W-1:0] i_data3,
    input  logic [DATA_W-1:0] i_data4,
    input  logic [DATA_W-1:0] i_data5,
    input  logic [DATA_W-1:0] i_data6,
    input  logic [DATA_W-1:0] i_data7,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_last,
    output logic              o_overflow,
    output logic              o_busy
);

    logic [1:0]              full;
    bank_t                   wr_bank;
    bank_t                   rd_bank;
    bank_t                   rd_bank_n;
    bank_t                   ld_bank;
    logic [2:0]              wr_row;
    state_t                  state;
    state_t                  state_n;
    logic [5:0]              idx;
    logic [5:0]              idx_n;
    logic [5:0]              ld_idx;
    logic [5:0]              rd_pos;
    logic                    valid_n;
    logic                    last_n;
    logic                    load;
    logic                    free;
    logic                    wr_ok;
    logic [1:0]              wr_en;
    logic [BLK_N*DATA_W-1:0] row_dat;
    logic [DATA_W-1:0]       bank_rd [2];

    assign row_dat = {i_data7, i_data6, i_data5, i_data4,
                      i_data3, i_data2, i_data1, i_data0};

    // A bank being released this cycle may take its row 0 in the same cycle.
    assign wr_ok    = i_valid && (!full[wr_bank] || (free && (rd_bank == wr_bank)));
    assign wr_en[0] = wr_ok && (wr_bank == 1'b0);
    assign wr_en[1] = wr_ok && (wr_bank == 1'b1);
    assign o_busy   = (|full) || (wr_row != 3'd0);

`ifdef ZIGZAG_SCAN_EN
    assign rd_pos = ZIGZAG[ld_idx];
`else
    assign rd_pos = ld_idx;
`endif

    block_bank #(.DATA_W(DATA_W)) u_bank0 (
        .i_clk   (i_clk),
        .wr_en   (wr_en[0]),
        .wr_row  (wr_row),
        .wr_data (row_dat),
        .rd_addr (rd_pos),
        .rd_data (bank_rd[0])
    );

    block_bank #(.DATA_W(DATA_W)) u_bank1 (
        .i_clk   (i_clk),
        .wr_en   (wr_en[1]),
        .wr_row  (wr_row),
        .wr_data (row_dat),
        .rd_addr (rd_pos),
        .rd_data (bank_rd[1])
    );

    always_comb begin
        state_n   = state;
        idx_n     = idx;
        rd_bank_n = rd_bank;
        ld_bank   = rd_bank;
        ld_idx    = idx;
        load      = 1'b0;
        free      = 1'b0;
        valid_n   = o_valid;
        last_n    = o_last;
        case (state)
            S_IDLE: begin
                if (full[rd_bank]) begin
                    load    = 1'b1;
                    ld_idx  = 6'd0;
                    idx_n   = 6'd0;
                    valid_n = 1'b1;
                    last_n  = 1'b0;
                    state_n = S_STREAM;
                end
            end
            S_STREAM: begin
                if (i_ready) begin
                    if (idx == 6'd63) begin
                        free      = 1'b1;
                        rd_bank_n = ~rd_bank;
                        last_n    = 1'b0;
                        if (full[~rd_bank]) begin
                            load    = 1'b1;
                            ld_bank = ~rd_bank;
                            ld_idx  = 6'd0;
                            idx_n   = 6'd0;
                        end else begin
                            valid_n = 1'b0;
                            state_n = S_IDLE;
                        end
                    end else begin
                        load   = 1'b1;
                        ld_idx = idx + 6'd1;
                        idx_n  = idx + 6'd1;
                        last_n = (idx == 6'd62);
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= S_IDLE;
            idx     <= 6'd0;
            rd_bank <= 1'b0;
            o_data  <= '0;
            o_valid <= 1'b0;
            o_last  <= 1'b0;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            rd_bank <= rd_bank_n;
            o_valid <= valid_n;
            o_last  <= last_n;
            if (load) begin
                o_data <= bank_rd[ld_bank];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_bank    <= 1'b0;
            wr_row     <= 3'd0;
            full       <= 2'b00;
            o_overflow <= 1'b0;
        end else begin
            if (free) begin
                full[rd_bank] <= 1'b0;
            end
            if (wr_ok) begin
                wr_row <= wr_row + 3'd1;
                if (wr_row == 3'd7) begin
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= ~wr_bank;
                end
            end
            if (i_valid && !wr_ok) begin
                o_overflow <= 1'b1;
            end
        end
    end

endmodule
